bdcc_tx_sched: RTL and testbench



---
 rtl/bdcc_tx_sched_if.sv | 36 +++
 rtl/bdcc_tx_sched.sv | 213 +++++++++++++++++++++
 tb/tb_bdcc_tx_sched.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bdcc_tx_sched_if.sv
// ---------------------------------------------------------------------------
// bdcc_tx_sched_if
// Bundles the requester handshake and the BDCC serial line of the transmit
// scheduler.
//   iReq  [NREQ]     request per requester, held until acked
//   iData [16*NREQ]  word of requester i at bits [16i+15:16i]
//   oAck  [NREQ]     one-hot pulse on the edge the word is latched
//   oBusy            frame in progress (grant edge through end of IFG)
//   oDone            pulse on the last IFG cycle
//   HO / IM1 / IM0   frame sync and bipolar data pulse lines
// Modports:
//   slave  - the scheduler (consumes requests, drives the line)
//   master - the requester side
// ---------------------------------------------------------------------------
interface bdcc_tx_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    iReq;
  logic [16*NREQ-1:0] iData;
  logic [NREQ-1:0]    oAck;
  logic               oBusy;
  logic               oDone;
  logic               HO;
  logic               IM1;
  logic               IM0;

  modport slave (
    input  iReq, iData,
    output oAck, oBusy, oDone, HO, IM1, IM0
  );

  modport master (
    output iReq, iData,
    input  oAck, oBusy, oDone, HO, IM1, IM0
  );
endinterface

// File: rtl/bdcc_tx_sched.sv
// ---------------------------------------------------------------------------
// bdcc_tx_sched
// Round-robin arbiter plus word serializer sharing one BDCC transmit line
// between NREQ requesters. Each grant emits one frame: HO held high for
// HO_LEN clocks, then the data bits MSB first, each bit a PULSE_LEN pulse on
// IM1 ('1') or IM0 ('0') followed by GAP_LEN clocks with both lines low, then
// IFG_LEN idle clocks.
// Ports:
//   clk   system clock, rising edge
//   nRST  asynchronous active-low reset
//   bus   bdcc_tx_sched_if.slave (iReq/iData in; oAck/oBusy/oDone/HO/IM1/IM0 out)
// Option:
//   BDCC_PARITY_EN - append a 17th bit carrying odd parity over the word.
// All outputs are registered; reset clears them without waiting for a clock.
// ---------------------------------------------------------------------------
module bdcc_tx_sched #(
  parameter int NREQ      = 4,
  parameter int HO_LEN    = 8,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 2,
  parameter int IFG_LEN   = 4
) (
  input  logic            clk,
  input  logic            nRST,
  bdcc_tx_sched_if.slave  bus
);

`ifdef BDCC_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif

  localparam int MAX_AB = (HO_LEN > PULSE_LEN) ? HO_LEN : PULSE_LEN;
  localparam int MAX_CD = (GAP_LEN > IFG_LEN) ? GAP_LEN : IFG_LEN;
  localparam int MAXLEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXLEN + 1);
  localparam int BW     = $clog2(NBITS + 1);
  localparam int PW     = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_BIT_ON  = 3'd2,
    S_BIT_OFF = 3'd3,
    S_IFG     = 3'd4
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [NBITS-1:0]  r_shift;
  logic [PW-1:0]     r_last;
  logic [NREQ-1:0]   r_ack;
  logic              r_busy;
  logic              r_done;
  logic              r_ho;
  logic              r_im1;
  logic              r_im0;

  state_t            w_state_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [BW-1:0]     w_bit_nxt;
  logic [NBITS-1:0]  w_shift_nxt;
  logic [NBITS-1:0]  w_load;
  logic [15:0]       w_word;
  logic              w_gnt_vld;
  logic [PW-1:0]     w_gnt_idx;
  logic [PW-1:0]     w_idx;
  logic [NREQ-1:0]   w_ack_d;
  logic              w_busy_d;
  logic              w_done_d;
  logic              w_ho_d;
  logic              w_im1_d;
  logic              w_im0_d;

  // Round-robin scan starting just after the last grantee.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = PW'((int'(r_last) + k) % NREQ);
      if (!w_gnt_vld && bus.iReq[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  // Word mux for the winner; constant slice bases keep the select simple.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == PW'(i)) w_word = bus.iData[16*i +: 16];
    end
  end

`ifdef BDCC_PARITY_EN
  // Parity rides as the LSB so the plain MSB-first shift sends it last.
  assign w_load = {w_word, ~^w_word};
`else
  assign w_load = w_word;
`endif

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_last  <= PW'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      if (r_state == S_IDLE && w_gnt_vld) r_last <= w_gnt_idx;
    end
  end

  // Data shift register carries no control meaning, so it is not reset.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // Next-state logic; every phase restarts the cycle counter at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_gnt_vld) begin
          w_state_nxt = S_SYNC;
          w_shift_nxt = w_load;
          w_bit_nxt   = '0;
        end
      end
      S_SYNC: begin
        if (r_cnt == CW'(HO_LEN - 1)) begin
          w_state_nxt = S_BIT_ON;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      S_BIT_ON: begin
        if (r_cnt == CW'(PULSE_LEN - 1)) begin
          w_state_nxt = S_BIT_OFF;
          w_cnt_nxt   = '0;
        end
      end
      S_BIT_OFF: begin
        if (r_cnt == CW'(GAP_LEN - 1)) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_shift[NBITS-2:0], 1'b0};
          w_bit_nxt   = r_bit + BW'(1);
          if (r_bit == BW'(NBITS - 1)) w_state_nxt = S_IFG;
          else                         w_state_nxt = S_BIT_ON;
        end
      end
      S_IFG: begin
        if (r_cnt == CW'(IFG_LEN - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: the registered outputs reflect the state being entered,
  // so each line changes on the same edge as the state transition.
  always_comb begin
    w_ack_d = '0;
    if (r_state == S_IDLE && w_gnt_vld) w_ack_d[w_gnt_idx] = 1'b1;
    w_busy_d = (w_state_nxt != S_IDLE);
    w_ho_d   = (w_state_nxt == S_SYNC);
    w_im1_d  = (w_state_nxt == S_BIT_ON) &&  w_shift_nxt[NBITS-1];
    w_im0_d  = (w_state_nxt == S_BIT_ON) && !w_shift_nxt[NBITS-1];
    w_done_d = (w_state_nxt == S_IFG) && (w_cnt_nxt == CW'(IFG_LEN - 1));
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_ack  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ho   <= 1'b0;
      r_im1  <= 1'b0;
      r_im0  <= 1'b0;
    end else begin
      r_ack  <= w_ack_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
      r_ho   <= w_ho_d;
      r_im1  <= w_im1_d;
      r_im0  <= w_im0_d;
    end
  end

  assign bus.oAck  = r_ack;
  assign bus.oBusy = r_busy;
  assign bus.oDone = r_done;
  assign bus.HO    = r_ho;
  assign bus.IM1   = r_im1;
  assign bus.IM0   = r_im0;

endmodule

// File: tb/tb_bdcc_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_bdcc_tx_sched
// Directed bench for bdcc_tx_sched at default parameters. Each frame is
// decoded from the line and compared with hand-derived values: HO length,
// bit pattern, pulse total, oDone position (last cycle of the frame, counting
// the first HO-high cycle as cycle 1), oBusy span, ack order and idle gap.
// Honours BDCC_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bdcc_tx_sched;

  localparam int NREQ = 4;
`ifdef BDCC_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif
  // 8 + NBITS*(2+2) + 4 clocks per frame
  localparam int FLEN = 8 + NBITS * 4 + 4;

  logic clk;
  logic nRST;
  int   n_chk;
  int   n_bad;
  int   inv_bad;

  bdcc_tx_sched_if #(.NREQ(NREQ)) bus ();

  bdcc_tx_sched #(
    .NREQ(NREQ), .HO_LEN(8), .PULSE_LEN(2), .GAP_LEN(2), .IFG_LEN(4)
  ) u_dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Line invariants watched continuously.
  always @(negedge clk) begin
    if (nRST) begin
      if (bus.HO && (bus.IM1 || bus.IM0)) inv_bad++;
      if (bus.IM1 && bus.IM0) inv_bad++;
      if (!$onehot0(bus.oAck)) inv_bad++;
    end
  end

  // Waits for the ack of requester gi, drops that request, then decodes the
  // whole frame. Returns on the negedge after the last frame cycle (IDLE).
  task automatic frame(input int gi, input logic [15:0] w, input int exp_wait,
                       input int late_idx);
    int t, ho_n, im_n, rise_n, done_n, done_c, busy_n, ack_x;
    logic prev;
    logic [NBITS-1:0] dec;
    logic [NBITS-1:0] expw;
`ifdef BDCC_PARITY_EN
    expw = {w, ~^w};
`else
    expw = w;
`endif
    t = 0;
    while (bus.oAck == '0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_wait >= 0) check("ack_wait", 32'(t), 32'(exp_wait));
    check("ack_idx", 32'(bus.oAck), 32'(1) << gi);
    check("ho_rise", 32'(bus.HO), 32'd1);
    bus.iReq[gi] = 1'b0;
    ho_n = 0; im_n = 0; rise_n = 0; done_n = 0; done_c = 0; busy_n = 0; ack_x = 0;
    prev = 1'b0;
    dec  = '0;
    for (int c = 1; c <= FLEN; c++) begin
      if (bus.HO) ho_n++;
      if (bus.IM1 || bus.IM0) begin
        im_n++;
        if (!prev) begin
          rise_n++;
          dec = {dec[NBITS-2:0], bus.IM1};
        end
      end
      prev = bus.IM1 || bus.IM0;
      if (bus.oDone) begin
        done_n++;
        done_c = c;
      end
      if (bus.oBusy) busy_n++;
      if (c > 1 && bus.oAck != '0) ack_x++;
      if (c == 20 && late_idx >= 0) bus.iReq[late_idx] = 1'b1;
      @(negedge clk);
    end
    check("ho_len",    32'(ho_n),   32'd8);
    check("bit_count", 32'(rise_n), 32'(NBITS));
    check("pulse_clk", 32'(im_n),   32'(NBITS * 2));
    check("word",      32'(dec),    32'(expw));
    check("done_cnt",  32'(done_n), 32'd1);
    check("done_cyc",  32'(done_c), 32'(FLEN));
    check("busy_len",  32'(busy_n), 32'(FLEN));
    check("ack_extra", 32'(ack_x),  32'd0);
    check("busy_end",  32'(bus.oBusy), 32'd0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out", 32'({bus.oAck, bus.oBusy, bus.oDone, bus.HO, bus.IM1, bus.IM0}), 32'd0);
    nRST = 1'b1;
  endtask

  initial begin
    int t;
    n_chk   = 0;
    n_bad   = 0;
    inv_bad = 0;
    nRST      = 1'b0;
    bus.iReq  = '0;
    bus.iData = '0;
    @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    check("idle_quiet", 32'({bus.oAck, bus.oBusy, bus.HO, bus.IM1, bus.IM0}), 32'd0);

    // Single request
    bus.iData[15:0] = 16'hA5C3;
    bus.iReq = 4'b0001;
    frame(0, 16'hA5C3, 1, -1);

    // Round robin after a pointer reset
    do_reset();
    bus.iData = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    bus.iReq  = 4'b1111;
    frame(0, 16'h1234, 1, -1);
    frame(1, 16'h5678, 1, -1);
    frame(2, 16'h9ABC, 1, -1);
    frame(3, 16'hDEF0, 1, -1);

    // Contention with immediate re-request of requester 0
    bus.iData = {16'h0000, 16'h0003, 16'h0000, 16'h0001};
    bus.iReq  = 4'b0101;
    frame(0, 16'h0001, 1, -1);
    bus.iData[15:0] = 16'h8000;
    bus.iReq[0] = 1'b1;
    frame(2, 16'h0003, 1, -1);
    frame(0, 16'h8000, 1, -1);

    // Request arriving while busy
    bus.iData = {16'h0000, 16'h0000, 16'h0F0F, 16'hFFFF};
    bus.iReq  = 4'b0001;
    frame(0, 16'hFFFF, 1, 1);
    frame(1, 16'h0F0F, 1, -1);

    // Reset in the middle of a bit pulse
    bus.iData = {16'hC001, 16'h0000, 16'h0000, 16'h0000};
    bus.iReq  = 4'b1000;
    t = 0;
    while (!(bus.IM1 || bus.IM0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("bit_on_seen", 32'(t < 200), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("rst_async", 32'({bus.HO, bus.IM1, bus.IM0, bus.oBusy}), 32'd0);
    @(negedge clk);
    bus.iData = {16'h4444, 16'h3333, 16'h2222, 16'h3C3C};
    bus.iReq  = 4'b1111;
    @(negedge clk);
    nRST = 1'b1;
    frame(0, 16'h3C3C, 1, -1);
    bus.iReq = '0;
    repeat (4) @(negedge clk);
    check("final_idle", 32'({bus.oAck, bus.oBusy, bus.HO}), 32'd0);
    check("invariants", 32'(inv_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
